// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the bcd2bin / bin2bcd converters.
package bcd_pkg;

    localparam int unsigned BCD_DIGITS    = 4;
    localparam int unsigned BCD_W         = 4;
    localparam int unsigned BCD_MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd2bin_state_t;

    // True when any packed digit lies outside 0..9.
    function automatic logic bcd_has_invalid(input logic [BCD_DIGITS*BCD_W-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (d[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX_DIGIT)) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble digit correction: subtract 3 when the shifted digit is 8 or more.
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_d,
    output logic [BCD_W-1:0] o_d_c
);

    assign o_d_c = i_d[BCD_W-1] ? (i_d - BCD_W'(3)) : i_d;

endmodule

// File: rtl/bcd2bin.sv
// Sequential 4-digit BCD to N-bit binary converter (reverse double-dabble, one shift per clock).
module bcd2bin
    import bcd_pkg::*;
#(
    parameter int unsigned N = 14
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       bcd3,
    input  logic [3:0]       bcd2,
    input  logic [3:0]       bcd1,
    input  logic [3:0]       bcd0,
    output logic [N-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err
);

    localparam int unsigned B_W   = BCD_DIGITS * BCD_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    bcd2bin_state_t   r_state, w_state_nxt;
    logic [B_W-1:0]   r_b, w_b_nxt, w_b_shift, w_b_corr, w_digits;
    logic [N-1:0]     r_r, w_r_nxt, w_r_shift;
    logic [N-1:0]     r_bin, w_bin_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_err, w_err_nxt;
    logic             w_invalid;

    assign w_digits  = {bcd3, bcd2, bcd1, bcd0};
    assign w_invalid = bcd_has_invalid(w_digits);
    assign w_b_shift = {1'b0, r_b[B_W-1:1]};
    assign w_r_shift = {r_b[0], r_r[N-1:1]};

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_sub3
        bcd_digit_sub3 u_sub3 (
            .i_d   (w_b_shift[g*BCD_W +: BCD_W]),
            .o_d_c (w_b_corr[g*BCD_W +: BCD_W])
        );
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_r_nxt     = r_r;
        w_cnt_nxt   = r_cnt;
        w_bin_nxt   = r_bin;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_ovf_nxt   = r_ovf;
        w_err_nxt   = r_err;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_b_nxt    = w_digits;
                    w_r_nxt    = '0;
                    w_cnt_nxt  = '0;
                    w_done_nxt = 1'b0;
                    w_ovf_nxt  = 1'b0;
                    w_err_nxt  = 1'b0;
                    if (w_invalid) begin
                        w_state_nxt = DONE;
                        w_err_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_bin_nxt   = '0;
                    end else begin
                        w_state_nxt = SHIFT;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                w_b_nxt   = w_b_corr;
                w_r_nxt   = w_r_shift;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // Leftover weight in b after N shifts means the value did not fit.
                if (r_cnt == CNT_W'(N - 1)) begin
                    w_bin_nxt   = w_r_shift;
                    w_ovf_nxt   = |w_b_corr;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_b     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_b     <= w_b_nxt;
            r_r     <= w_r_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bin   <= w_bin_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ovf   <= w_ovf_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bin  = r_bin;
    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd2bin.sv
// Bench for bcd2bin: directed plan plus random digits, N=7 and N=14 instances against an arithmetic model.
`timescale 1ns/1ps
module tb_bcd2bin;

    logic        clk;
    logic        rst;
    logic        start7, start14;
    logic [3:0]  bcd3, bcd2, bcd1, bcd0;
    logic [6:0]  bin7;
    logic [13:0] bin14;
    logic        busy7, done7, ovf7, err7;
    logic        busy14, done14, ovf14, err14;

    int total = 0;
    int bad   = 0;

    bcd2bin #(.N(7)) dut7 (
        .clk(clk), .rst(rst), .start(start7),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .bin(bin7), .busy(busy7), .done(done7), .ovf(ovf7), .err(err7)
    );

    bcd2bin #(.N(14)) dut14 (
        .clk(clk), .rst(rst), .start(start14),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .bin(bin14), .busy(busy14), .done(done14), .ovf(ovf14), .err(err14)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int o_bin(input int sel);
        return (sel == 7) ? int'(bin7) : int'(bin14);
    endfunction
    function automatic int o_busy(input int sel);
        return (sel == 7) ? int'(busy7) : int'(busy14);
    endfunction
    function automatic int o_done(input int sel);
        return (sel == 7) ? int'(done7) : int'(done14);
    endfunction
    function automatic int o_ovf(input int sel);
        return (sel == 7) ? int'(ovf7) : int'(ovf14);
    endfunction
    function automatic int o_err(input int sel);
        return (sel == 7) ? int'(err7) : int'(err14);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 7) start7 = v;
        else start14 = v;
    endtask

    // Wait for done, counting edges from the accepting edge (lat holds edges already elapsed).
    task automatic wait_done(input int sel, input int lat_in, output int lat);
        lat = lat_in;
        while (o_done(sel) == 0 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    // Issue one conversion and check it against the arithmetic model.
    task automatic conv(input int sel, input int d3, input int d2, input int d1, input int d0,
                        input string tag);
        int value, exp_bin, exp_ovf, lat;
        logic invalid;
        invalid = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
        value   = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
        exp_bin = invalid ? 0 : value % (1 << sel);
        exp_ovf = (!invalid && value >= (1 << sel)) ? 1 : 0;
        bcd3 = 4'(d3); bcd2 = 4'(d2); bcd1 = 4'(d1); bcd0 = 4'(d0);
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        // Digits are free to change once accepted.
        bcd3 = 4'($urandom); bcd2 = 4'($urandom); bcd1 = 4'($urandom); bcd0 = 4'($urandom);
        if (invalid) begin
            check({tag, " err_done"}, o_done(sel), 1);
            check({tag, " err_flag"}, o_err(sel), 1);
            check({tag, " err_bin"},  o_bin(sel), 0);
            check({tag, " err_busy"}, o_busy(sel), 0);
            check({tag, " err_ovf"},  o_ovf(sel), 0);
        end else begin
            check({tag, " busy"}, o_busy(sel), 1);
            check({tag, " done_low"}, o_done(sel), 0);
            wait_done(sel, 0, lat);
            check({tag, " latency"}, lat, sel);
            check({tag, " bin"}, o_bin(sel), exp_bin);
            check({tag, " ovf"}, o_ovf(sel), exp_ovf);
            check({tag, " err"}, o_err(sel), 0);
            check({tag, " busy_end"}, o_busy(sel), 0);
        end
    endtask

    initial begin
        int lat;
        int saw_done;
        int d[4];
        rst = 1'b1; start7 = 1'b0; start14 = 1'b0;
        bcd3 = '0; bcd2 = '0; bcd1 = '0; bcd0 = '0;
        repeat (3) tick();
        check("reset7",  {25'd0, bin7, busy7, done7, ovf7, err7}, 0);
        check("reset14", {18'd0, bin14, busy14, done14, ovf14, err14}, 0);
        rst = 1'b0;
        tick();

        conv(7, 0, 0, 5, 3, "n7_53");
        conv(7, 0, 1, 2, 0, "n7_120");
        conv(7, 0, 1, 2, 8, "n7_128");
        conv(14, 9, 9, 9, 9, "n14_9999");
        conv(14, 0, 0, 0, 0, "n14_0");
        conv(14, 0, 0, 10, 0, "n14_badA");
        conv(14, 1, 2, 3, 4, "n14_after_err");

        // A second start during SHIFT must be ignored.
        bcd3 = 4'd1; bcd2 = 4'd2; bcd1 = 4'd3; bcd0 = 4'd4;
        start14 = 1'b1;
        tick();
        start14 = 1'b0;
        repeat (2) tick();
        bcd3 = 4'd9; bcd2 = 4'd8; bcd1 = 4'd7; bcd0 = 4'd6;
        start14 = 1'b1;
        tick();
        start14 = 1'b0;
        wait_done(14, 3, lat);
        check("midstart latency", lat, 14);
        check("midstart bin", int'(bin14), 1234);

        // Reset during the third shift aborts the conversion.
        bcd3 = 4'd5; bcd2 = 4'd5; bcd1 = 4'd5; bcd0 = 4'd5;
        start14 = 1'b1;
        tick();
        start14 = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        start14 = 1'b1;
        tick();
        rst = 1'b0;
        start14 = 1'b0;
        check("abort outputs", {18'd0, bin14, busy14, done14, ovf14, err14}, 0);
        saw_done = 0;
        repeat (20) begin
            tick();
            if (done14) saw_done = 1;
        end
        check("abort no done", saw_done, 0);
        conv(14, 4, 3, 2, 1, "n14_after_abort");

        // start held high while DONE restarts on every done.
        bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd9; bcd0 = 4'd9;
        start7 = 1'b1;
        tick();
        check("hold first busy", int'(busy7), 1);
        for (int k = 0; k < 3; k++) begin
            wait_done(7, 0, lat);
            check("hold latency", lat, 7);
            check("hold bin", int'(bin7), 99);
            tick();
            check("hold restart done", int'(done7), 0);
            check("hold restart busy", int'(busy7), 1);
        end
        start7 = 1'b0;
        wait_done(7, 0, lat);
        check("hold final latency", lat, 7);

        // Random conversions on both widths, with occasional invalid digits.
        for (int n = 0; n < 24; n++) begin
            for (int j = 0; j < 4; j++) d[j] = int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 3)] = int'($urandom_range(10, 15));
            conv((n % 2 == 0) ? 7 : 14, d[3], d[2], d[1], d[0], "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
